proc_inst_encoder: RTL and testbench
====================================

Name: proc_inst_encoder

Overview:
- Inverse of the datapath immediate generator: assembles a 32-bit RV32 instruction word from an immediate, an immediate type and register/function fields.
- Range-checks the immediate for its type.
- Sits in front of test-memory loaders and the self-checking instruction-source harness.
- val/rdy on both sides, with a 2-entry output queue that absorbs backpressure.

Parameters:
- None. All widths are fixed by RV32.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  request valid
- in_rdy  output  1  request ready
- in_imm_type  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=R (no imm), 6..7 illegal
- in_imm  input  32  immediate value, pre-shift (B/J byte offsets, U full value)
- in_opcode  input  7  opcode field
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field, used for type R only
- out_val  output  1  response valid
- out_rdy  input  1  response ready
- out_inst  output  32  encoded instruction
- out_err  output  1  immediate out of range, or illegal type
- err_count  output  16  present only with the optional feature

Behaviour:
- Encoding is combinational on the in_* fields; the result and error flag are written into a 2-entry FIFO on a fire (in_val && in_rdy).
- Field layouts:
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - R: funct7, rs2, rs1, funct3, rd, opcode
- Range rules (err=1 when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, never errs.
  - Types 6..7: always err.
- When err=1, the stored out_inst is 32'h0.
- Shift-immediate I-type instructions (e.g. SRAI) carry funct7 inside in_imm[11:5]; in_funct7 is ignored for I-type.
- Latency: an entry accepted at edge N is visible (out_val=1) in the cycle after edge N. There is no combinational in-to-out bypass.
- in_rdy = !full. It is registered state only and never depends on out_rdy in the same cycle.
- out_val = !empty. out_inst and out_err show the head entry; both are 0 when the FIFO is empty.
- Simultaneous enqueue and dequeue with one entry held: count stays 1 and order is preserved.
- When full, in_rdy=0 even if out_rdy=1 that cycle. The slot frees on the next edge.
- Throughput is 1 per cycle while out_rdy is held high.
- Pointers are 1-bit and wrap modulo 2.
- Reset: count=0, pointers=0, out_val=0, in_rdy=1, out_inst=0, out_err=0. Reset mid-operation discards all queued entries. A fire asserted in the same cycle as reset is dropped.

Optional Feature:
- Macro: PROC_INST_ENCODER_ERR_COUNT_EN.
- When defined:
  - The err_count port exists.
  - It is a 16-bit counter that increments on every fire whose err=1.
  - It saturates at 16'hFFFF and clears to 0 on reset.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package proc_inst_encoder_pkg holds:
  - An imm_type enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R) matching the datapath immediate-generator encoding.
  - A packed struct {inst[31:0], err}.
  - Opcode constants used by the bench.
- One natural sub-module: proc_inst_encoder_queue, a 2-entry synchronous FIFO parameterised on entry width.
- Encode and range-check logic stays in the top module.

Test Plan:
- I-type: type=0, imm=32'hFFFFF955, rs1=10, funct3=0, rd=21, opcode=7'h13, out_rdy=1 -> next cycle out_val=1, out_inst=32'h95550A93, out_err=0.
- B-type: type=2, imm=32'hFFFFFFFC, rs1=1, rs2=2, funct3=1, opcode=7'h63 -> out_inst=32'hFE209EE3. Same request with imm=3 -> out_err=1, out_inst=0.
- J/U: type=4, imm=8, rd=1, opcode=7'h6F -> 32'h008000EF. Type=3, imm=32'h12345678 -> out_err=1, out_inst=0. With the macro defined, err_count reaches 2 after both error cases.
- Backpressure: out_rdy=0, offer 3 back-to-back requests -> first two accepted, in_rdy=0 on the third. Then raise out_rdy -> three results emerge in order, with exactly one dequeue per cycle.
- Streaming: out_rdy=1, 8 consecutive requests -> 8 consecutive out_val cycles, each one cycle after its accept, with no bubbles.
- Reset mid-operation: fill the queue with 2 entries, assert reset for 1 cycle -> out_val=0 and in_rdy=1 the next cycle, the old entries never appear, and err_count=0.

Source files
------------

// File: rtl/proc_inst_encoder_pkg.sv
// Shared types and constants for the RV32 instruction encoder.
// Imported by proc_inst_encoder, its queue, and the testbench.
package proc_inst_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_R = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_entry_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/proc_inst_encoder_queue.sv
// Two-entry synchronous FIFO with val/rdy on both sides.
// enq_rdy is derived from registered occupancy only; empty reads as zero.
module proc_inst_encoder_queue #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [WIDTH-1:0] deq_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign enq   = enq_val && !full;
    assign deq   = deq_rdy && !empty;

    assign enq_rdy  = !full;
    assign deq_val  = !empty;
    assign deq_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (enq) wptr <= ~wptr;
            if (deq) rptr <= ~rptr;
            count <= count + 2'(enq) - 2'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) mem[wptr] <= enq_data;
    end

endmodule

// File: rtl/proc_inst_encoder.sv
// RV32 instruction encoder: packs imm/type/register fields into an instruction word,
// range-checks the immediate, and queues results. Optional: PROC_INST_ENCODER_ERR_COUNT_EN.
module proc_inst_encoder
    import proc_inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [2:0]  in_imm_type,
    input  logic [31:0] in_imm,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_inst,
    output logic        out_err
`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    enc_entry_t  enc;
    enc_entry_t  head;
    logic [31:0] raw;
    logic        ok;
    logic        fire;

    // Shift-immediate I-types carry funct7 in imm[11:5], so in_funct7 is only used for R.
    always_comb begin
        raw = '0;
        ok  = 1'b0;
        case (in_imm_type)
            IMM_I: begin
                raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                ok  = (in_imm[31:11] == {21{in_imm[11]}});
            end
            IMM_S: begin
                raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                ok  = (in_imm[31:11] == {21{in_imm[11]}});
            end
            IMM_B: begin
                raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
                ok  = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
            end
            IMM_U: begin
                raw = {in_imm[31:12], in_rd, in_opcode};
                ok  = (in_imm[11:0] == 12'd0);
            end
            IMM_J: begin
                raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                ok  = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
            end
            IMM_R: begin
                raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                ok  = 1'b1;
            end
            default: begin
                raw = '0;
                ok  = 1'b0;
            end
        endcase
        enc.err  = !ok;
        enc.inst = ok ? raw : '0;
    end

    assign fire = in_val && in_rdy;

    proc_inst_encoder_queue #(
        .WIDTH($bits(enc_entry_t))
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (in_val),
        .enq_rdy  (in_rdy),
        .enq_data (enc),
        .deq_val  (out_val),
        .deq_rdy  (out_rdy),
        .deq_data (head)
    );

    assign out_inst = head.inst;
    assign out_err  = head.err;

`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (fire && enc.err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_proc_inst_encoder.sv
// Self-checking bench for proc_inst_encoder: directed vectors plus randomized traffic
// checked cycle-by-cycle against a queue-based reference model.
module tb_proc_inst_encoder;
    import proc_inst_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [2:0]  in_imm_type;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic        out_err;
`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    proc_inst_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_imm_type (in_imm_type),
        .in_imm      (in_imm),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_inst    (out_inst),
        .out_err     (out_err)
`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder: range rules expressed as signed value bounds and alignment.
    function automatic enc_entry_t ref_encode(input logic [2:0] t, input logic [31:0] imm,
                                              input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7);
        enc_entry_t e;
        int         s;
        bit         even;
        bit         ok;
        s    = $signed(imm);
        even = ((imm % 32'd2) == 0);
        e.inst = '0;
        case (t)
            3'd0: begin ok = (s >= -2048 && s <= 2047);
                  e.inst = {imm[11:0], rs1, f3, rd, op}; end
            3'd1: begin ok = (s >= -2048 && s <= 2047);
                  e.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
            3'd2: begin ok = (s >= -4096 && s <= 4095) && even;
                  e.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; end
            3'd3: begin ok = ((imm % 32'd4096) == 0);
                  e.inst = {imm[31:12], rd, op}; end
            3'd4: begin ok = (s >= -1048576 && s <= 1048575) && even;
                  e.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; end
            3'd5: begin ok = 1'b1;
                  e.inst = {f7, rs2, rs1, f3, rd, op}; end
            default: ok = 1'b0;
        endcase
        if (!ok) e.inst = '0;
        e.err = !ok;
        return e;
    endfunction

    enc_entry_t  exp_q[$];
    int unsigned m_errs = 0;
    bit          mon_en = 1'b0;

    // Check current DUT state against the model, then advance the model for the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            enc_entry_t e;
            bit         pushed;
            bit         popped;
            check_val("in_rdy", 32'(in_rdy), 32'(exp_q.size() < 2));
            check_val("out_val", 32'(out_val), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check_val("out_inst", out_inst, exp_q[0].inst);
                check_val("out_err", 32'(out_err), 32'(exp_q[0].err));
            end else begin
                check_val("out_inst_empty", out_inst, 32'h0);
                check_val("out_err_empty", 32'(out_err), 32'h0);
            end
`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
            check_val("err_count", 32'(err_count), m_errs);
`endif
            if (reset) begin
                exp_q.delete();
                m_errs = 0;
            end else begin
                pushed = in_val && (exp_q.size() < 2);
                popped = out_rdy && (exp_q.size() != 0);
                if (popped) void'(exp_q.pop_front());
                if (pushed) begin
                    e = ref_encode(in_imm_type, in_imm, in_opcode, in_rd, in_rs1, in_rs2,
                                   in_funct3, in_funct7);
                    exp_q.push_back(e);
                    if (e.err && m_errs != 32'hFFFF) m_errs++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7);
        in_val      = 1'b1;
        in_imm_type = t;
        in_imm      = imm;
        in_opcode   = op;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_funct3   = f3;
        in_funct7   = f7;
    endtask

    task automatic rand_req();
        logic [31:0] imm;
        logic [31:0] edges [10];
        edges = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF, 32'd4094, 32'hFFFFF000,
                  32'd4096, 32'h000FFFFE, 32'hFFF00000, 32'h00100000};
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = {20'($urandom), 12'h000};
            default: imm = edges[$urandom_range(0, 9)];
        endcase
        set_req(3'($urandom_range(0, 7)), imm, 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom));
    endtask

    initial begin
        reset   = 1'b1;
        out_rdy = 1'b1;
        set_req(3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        in_val  = 1'b0;
        step();
        step();
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_val("reset_out_val", 32'(out_val), 32'h0);
        check_val("reset_in_rdy", 32'(in_rdy), 32'h1);
        step();

        // Directed vectors from a freshly reset, drained queue
        set_req(IMM_I, 32'hFFFFF955, OP_IMM, 5'd21, 5'd10, 5'd0, 3'd0, 7'd0);
        step();
        in_val = 1'b0;
        @(negedge clk);
        check_val("i_type_inst", out_inst, 32'h95550A93);
        check_val("i_type_err", 32'(out_err), 32'h0);
        step();

        set_req(IMM_B, 32'hFFFFFFFC, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0);
        step();
        set_req(IMM_B, 32'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0);
        @(negedge clk);
        check_val("b_type_inst", out_inst, 32'hFE209EE3);
        step();
        in_val = 1'b0;
        @(negedge clk);
        check_val("b_odd_inst", out_inst, 32'h0);
        check_val("b_odd_err", 32'(out_err), 32'h1);
        step();

        set_req(IMM_J, 32'd8, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        set_req(IMM_U, 32'h12345678, OP_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        @(negedge clk);
        check_val("j_type_inst", out_inst, 32'h008000EF);
        step();
        in_val = 1'b0;
        @(negedge clk);
        check_val("u_low_inst", out_inst, 32'h0);
        check_val("u_low_err", 32'(out_err), 32'h1);
        step();
`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
        @(negedge clk);
        check_val("err_count_two", 32'(err_count), 32'd2);
        step();
`endif

        // Backpressure: two accepted, third blocked until a slot frees
        out_rdy = 1'b0;
        rand_req();
        step();
        rand_req();
        step();
        rand_req();
        @(negedge clk);
        check_val("bp_full_in_rdy", 32'(in_rdy), 32'h0);
        step();
        out_rdy = 1'b1;
        @(negedge clk);
        check_val("bp_full_rdy_hi", 32'(in_rdy), 32'h0);
        step();
        step();
        in_val = 1'b0;
        repeat (4) step();

        // Streaming: 8 back-to-back requests with out_rdy held high
        for (int i = 0; i < 8; i++) begin
            rand_req();
            step();
        end
        in_val = 1'b0;
        repeat (3) step();

        // Reset mid-operation with a full queue and a request offered during reset
        out_rdy = 1'b0;
        rand_req();
        step();
        rand_req();
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        in_val = 1'b0;
        @(negedge clk);
        check_val("mid_reset_out_val", 32'(out_val), 32'h0);
        check_val("mid_reset_in_rdy", 32'(in_rdy), 32'h1);
`ifdef PROC_INST_ENCODER_ERR_COUNT_EN
        check_val("mid_reset_err_count", 32'(err_count), 32'h0);
`endif
        out_rdy = 1'b1;
        repeat (3) step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) rand_req();
            else in_val = 1'b0;
            out_rdy = ($urandom_range(0, 2) != 0);
            reset   = ($urandom_range(0, 79) == 0);
            step();
        end
        reset   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b1;
        repeat (4) step();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
